// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the execute-stage multiply/divide unit.
package alu_pkg;
    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } muldiv_op_e;
    typedef enum logic [1:0] {IDLE, CALC, FIN} muldiv_state_e;
endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: start/busy/done handshake between decode and the multiply/divide unit.
interface muldiv_unit_if #(parameter int XLEN = 32);
    logic            start;
    logic            flush;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    modport master (output start, flush, funct3, op_a, op_b, input busy, done, result);
    modport slave  (input start, flush, funct3, op_a, op_b, output busy, done, result);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one result or quotient bit per cycle.
module muldiv_unit
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic          clk,
    input logic          rstn,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN + 1);
    muldiv_state_e     state;
    muldiv_op_e        fop;
    logic [2:0]        op;
    logic [CW-1:0]     cnt;
    logic [XLEN-1:0]   mb, ma, mbn, result, res;
    logic [2*XLEN:0]   acc, acc_nxt;
    logic [XLEN:0]     mul_sum, div_t, div_d;
    logic [2*XLEN-1:0] sel, fixed;
    logic              neg, done, a_sgn, b_sgn, div0, ovf, ge;
    // Multiply keeps the multiplier in acc's low half and shifts right; divide shifts the
    // dividend left out of the low half into the partial remainder above it.
    always_comb begin
        fop = muldiv_op_e'(bus.funct3);
        a_sgn = bus.op_a[XLEN-1] && (fop inside {MUL, MULH, MULHSU, DIV, REM});
        b_sgn = bus.op_b[XLEN-1] && (fop inside {MUL, MULH, DIV, REM});
        ma = a_sgn ? -bus.op_a : bus.op_a;
        mbn = b_sgn ? -bus.op_b : bus.op_b;
        div0 = bus.funct3[2] && bus.op_b == '0;
        ovf = (fop inside {DIV, REM}) && bus.op_a == {1'b1, {(XLEN-1){1'b0}}} && &bus.op_b;
        mul_sum = acc[2*XLEN:XLEN] + (acc[0] ? {1'b0, mb} : '0);
        div_t = acc[2*XLEN-1:XLEN-1];
        div_d = div_t - {1'b0, mb};
        ge = div_t >= {1'b0, mb};
        acc_nxt = op[2] ? (ge ? {div_d, acc[XLEN-2:0], 1'b1} : {div_t, acc[XLEN-2:0], 1'b0})
                        : {1'b0, mul_sum, acc[XLEN-1:1]};
        sel = op[2] ? {{XLEN{1'b0}}, op[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0]} : acc[2*XLEN-1:0];
        fixed = neg ? -sel : sel;
        res = (op[2] || op == MUL) ? fixed[XLEN-1:0] : fixed[2*XLEN-1:XLEN];
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            op     <= '0;
            cnt    <= '0;
            mb     <= '0;
            acc    <= '0;
            neg    <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (bus.start && !bus.flush) begin
                    op  <= bus.funct3;
                    cnt <= '0;
                    mb  <= mbn;
                    // Special cases preload the final quotient/remainder so FIN passes them through.
                    if (div0 || ovf) begin
                        state <= FIN;
                        neg   <= 1'b0;
                        acc   <= div0 ? {1'b0, bus.op_a, {XLEN{1'b1}}} : {{(XLEN+1){1'b0}}, bus.op_a};
                    end else begin
                        state <= CALC;
                        neg   <= (fop inside {REM, REMU}) ? a_sgn : a_sgn ^ b_sgn;
                        acc   <= {{(XLEN+1){1'b0}}, ma};
                    end
                end
                CALC: if (bus.flush) begin
                    state <= IDLE;
                end else begin
                    acc   <= acc_nxt;
                    cnt   <= cnt + CW'(1);
                    state <= (cnt == CW'(XLEN - 1)) ? FIN : CALC;
                end
                FIN: begin
                    state <= IDLE;
                    if (!bus.flush) begin
                        result <= res;
                        done   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.busy   = state != IDLE;
    assign bus.done   = done;
    assign bus.result = result;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed-vector checks of the RV32M multiply/divide unit.
module tb_muldiv_unit;
    import alu_pkg::*;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int checks = 0;
    int errors = 0;
    muldiv_unit_if #(.XLEN(32)) bus ();
    muldiv_unit #(.XLEN(32)) dut (.clk(clk), .rstn(rstn), .bus(bus));
    always #5 clk = ~clk;

    task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res, output logic busy_ok);
        @(negedge clk);
        bus.funct3 = f; bus.op_a = a; bus.op_b = b; bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        lat = 0;
        busy_ok = bus.busy;
        while (!bus.done && lat < 100) begin
            @(posedge clk); #1 lat++;
            if (!bus.done) busy_ok &= bus.busy;
        end
        busy_ok &= !bus.busy;
        res = bus.result;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = '0; bus.op_a = '0; bus.op_b = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", bus.result); end
        @(negedge clk) rstn = 1'b1;
    endtask

    task automatic test_ops();
        logic [2:0]  f   [12] = '{MUL, MULH, MULHU, MULHSU, DIV, REM, DIV, REM, DIVU, REMU, MULHU, MUL};
        logic [31:0] a   [12] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                  32'd7, 32'd7, 32'd100, 32'd100, 32'h00010000, 32'h12345678};
        logic [31:0] b   [12] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2,
                                  32'hFFFFFFFE, 32'hFFFFFFFE, 32'd7, 32'd7, 32'h00010000, 32'd0};
        logic [31:0] exp [12] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
                                  32'hFFFFFFFD, 32'd1, 32'd14, 32'd2, 32'd1, 32'd0};
        int lat;
        logic [31:0] res;
        logic busy_ok;
        for (int i = 0; i < 12; i++) begin
            run(f[i], a[i], b[i], lat, res, busy_ok);
            checks++; if (res !== exp[i]) begin errors++; $display("FAIL op%0d_result: got %h want %h", i, res, exp[i]); end
            checks++; if (lat !== 33) begin errors++; $display("FAIL op%0d_latency: got %0d want 33", i, lat); end
            checks++; if (busy_ok !== 1'b1) begin errors++; $display("FAIL op%0d_busy: got %b want 1", i, busy_ok); end
        end
    endtask

    task automatic test_special();
        logic [2:0]  f   [6] = '{DIVU, REMU, DIV, REM, DIV, REM};
        logic [31:0] a   [6] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'hFFFFFFF9, 32'hFFFFFFF9};
        logic [31:0] b   [6] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
        logic [31:0] exp [6] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF9};
        int lat;
        logic [31:0] res;
        logic busy_ok;
        for (int i = 0; i < 6; i++) begin
            run(f[i], a[i], b[i], lat, res, busy_ok);
            checks++; if (res !== exp[i]) begin errors++; $display("FAIL special%0d_result: got %h want %h", i, res, exp[i]); end
            checks++; if (lat !== 1) begin errors++; $display("FAIL special%0d_latency: got %0d want 1", i, lat); end
            checks++; if (busy_ok !== 1'b1) begin errors++; $display("FAIL special%0d_busy: got %b want 1", i, busy_ok); end
        end
    endtask

    task automatic test_ignore_start();
        int n = 0;
        @(negedge clk);
        bus.funct3 = DIVU; bus.op_a = 32'd100; bus.op_b = 32'd7; bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        while (!bus.done && n < 100) begin
            @(posedge clk); #1 n++;
            if (n == 5) begin bus.funct3 = MUL; bus.op_a = 32'd3; bus.op_b = 32'd4; bus.start = 1'b1; end
            if (n == 6) bus.start = 1'b0;
        end
        checks++; if (n !== 33) begin errors++; $display("FAIL ignore_latency: got %0d want 33", n); end
        checks++; if (bus.result !== 32'd14) begin errors++; $display("FAIL ignore_result: got %h want 0000000e", bus.result); end
    endtask

    task automatic test_flush();
        logic [31:0] prev = bus.result;
        logic seen = 1'b0;
        @(negedge clk);
        bus.funct3 = DIVU; bus.op_a = 32'd1000; bus.op_b = 32'd3; bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk); #1 bus.flush = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", bus.busy); end
        repeat (40) begin @(posedge clk); #1 seen |= bus.done; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_done: got %b want 0", seen); end
        checks++; if (bus.result !== prev) begin errors++; $display("FAIL flush_result: got %h want %h", bus.result, prev); end
        @(negedge clk);
        bus.flush = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1 bus.flush = 1'b0; bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_flush_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        @(negedge clk);
        bus.funct3 = MUL; bus.op_a = 32'd2; bus.op_b = 32'd3; bus.start = 1'b1;
        @(posedge clk); #1 bus.op_a = 32'd3; bus.op_b = 32'd4;
        while (!bus.done && n < 100) begin @(posedge clk); #1 n++; end
        checks++; if (n !== 33) begin errors++; $display("FAIL b2b_first_latency: got %0d want 33", n); end
        checks++; if (bus.result !== 32'd6) begin errors++; $display("FAIL b2b_first_result: got %h want 00000006", bus.result); end
        @(posedge clk); #1 bus.start = 1'b0;
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL b2b_done_drop: got %b want 0", bus.done); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b want 1", bus.busy); end
        n = 0;
        while (!bus.done && n < 100) begin @(posedge clk); #1 n++; end
        checks++; if (n !== 33) begin errors++; $display("FAIL b2b_second_latency: got %0d want 33", n); end
        checks++; if (bus.result !== 32'd12) begin errors++; $display("FAIL b2b_second_result: got %h want 0000000c", bus.result); end
    endtask

    task automatic test_reset_mid();
        logic seen = 1'b0;
        @(negedge clk);
        bus.funct3 = MUL; bus.op_a = 32'd7; bus.op_b = 32'd5; bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b want 0", bus.done); end
        checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL rstmid_result: got %h want 0", bus.result); end
        @(negedge clk) rstn = 1'b1;
        repeat (40) begin @(posedge clk); #1 seen |= bus.done; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_no_done: got %b want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_ops();
        test_special();
        test_ignore_start();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
